password_lock_ctrl: RTL and testbench
=====================================

PASSWORD_LOCK_CTRL -- requirements
Module: password_lock_ctrl

Interface
REQ-001 Parameter DEFAULT_PSWD, 16'h1234, BCD password loaded at reset.
REQ-002 Parameter OPEN_CYCLES, 150_000_000, unlock hold time in clk cycles (3 s at 50 MHz).
REQ-003 clk  in  1  system clock, 50 MHz; reset is asynchronous and active-high.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 identity  in  1  1 = user, 0 = administrator.
REQ-006 edit_switch  in  1  level; 1 requests admin password editing.
REQ-007 confirm  in  1  debounced button level; only its rising edge acts.
REQ-008 entered_pswd  in  16  four BCD digits from the user entry register.
REQ-009 new_pswd  in  16  four BCD digits from the admin entry register.
REQ-010 stored_pswd  out  16  current valid password.
REQ-011 state_code  out  3  FSM state encoding, for display.
REQ-012 time_of_error  out  2  consecutive failed attempts, 0..3.
REQ-013 unlock  out  1  door open.
REQ-014 alarm  out  1  lockout active.
REQ-015 editing  out  1  high in EDIT.
REQ-016 clr_entry  out  1  one-cycle pulse clearing the entry register.

Function
REQ-017 Confirm edge = confirm 1 now, 0 on previous clk sample; one edge per press.
REQ-018 States: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, ALARM=4, EDIT=5; all outputs registered.
REQ-019 IDLE: identity=0 and edit_switch=1 -> EDIT; else identity=1 and confirm edge -> ENTRY with clr_entry pulse.
REQ-020 ENTRY: confirm edge -> CHECK; identity falling to 0 -> IDLE with clr_entry pulse, no error counted (identity test wins over simultaneous edge).
REQ-021 CHECK lasts exactly one cycle: entered_pswd==stored_pswd -> OPEN, time_of_error<=0; mismatch -> time_of_error+1, ->ALARM if result is 3, else ->ENTRY with clr_entry pulse.
REQ-022 Latency: unlock rises on the second clk edge after the edge at which the confirm edge is detected.
REQ-023 OPEN: unlock=1; exits to IDLE after OPEN_CYCLES cycles or on earlier confirm edge, clr_entry pulse on exit.
REQ-024 ALARM: alarm=1, time_of_error held at 3, user edges ignored; identity=0 with confirm edge -> IDLE, time_of_error<=0, alarm<=0.
REQ-025 EDIT: confirm edge with every new_pswd nibble <=9 -> stored_pswd<=new_pswd, ->IDLE; any nibble >9 -> remain in EDIT, stored_pswd unchanged.
REQ-026 EDIT: edit_switch=0 or identity=1 -> IDLE, no save; abort wins over a simultaneous confirm edge.
REQ-027 time_of_error saturates at 3, never wraps.
REQ-028 Unlock timer counts 0..OPEN_CYCLES-1, cleared on every OPEN entry.

Reset
REQ-029 rst asynchronously forces IDLE, stored_pswd=DEFAULT_PSWD, time_of_error=0, unlock=alarm=editing=clr_entry=0, timer=0, edge-detect history=0.
REQ-030 Reset mid-operation (OPEN, ALARM, EDIT) discards all progress; stored password reverts to DEFAULT_PSWD.
REQ-031 First clk after rst release: a confirm already high produces no edge.

Structure
REQ-032 Shared package password_pkg holds state encoding, MAX_ERRORS=3, DIGIT_MAX=9, DEFAULT_PSWD default value.
REQ-033 Sub-module hold_timer (load, count, done) implements the OPEN_CYCLES counter.

Verification (bench OPEN_CYCLES=8)
REQ-034 Reset, user presses confirm, entered 16'h1234, confirm -> unlock=1 two edges later, held 8 cycles, then IDLE, time_of_error=0.
REQ-035 Three attempts with 16'h1111 -> time_of_error 1,2,3, alarm=1 at third CHECK; user confirm ignored; admin confirm -> alarm=0, time_of_error=0.
REQ-036 Admin edit_switch=1, new_pswd=16'h5678, confirm -> stored_pswd=16'h5678; user 16'h5678 unlocks, 16'h1234 fails.
REQ-037 EDIT with new_pswd=16'h12A4, confirm -> stored unchanged, state stays EDIT; edit_switch=0 with simultaneous confirm -> IDLE, no save.
REQ-038 rst asserted in OPEN and in ALARM -> all outputs at reset values immediately, stored_pswd=16'h1234.
REQ-039 Two failures, then correct 16'h1234 -> time_of_error returns to 0, next failure yields 1.

Source files
------------

// File: rtl/password_pkg.sv
// Shared definitions for the password lock: state encoding, limits,
// reset password and a BCD validity helper.
package password_pkg;

    localparam int PSWD_W = 16;
    localparam int DIGITS = 4;

    localparam logic [1:0]        MAX_ERRORS        = 2'd3;
    localparam logic [3:0]        DIGIT_MAX         = 4'd9;
    localparam logic [PSWD_W-1:0] DEFAULT_PSWD_INIT = 16'h1234;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_OPEN  = 3'd3,
        ST_ALARM = 3'd4,
        ST_EDIT  = 3'd5
    } state_t;

    // True when every nibble of the word is a legal decimal digit.
    function automatic logic bcd_valid(input logic [PSWD_W-1:0] p);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (p[i*4 +: 4] > DIGIT_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/password_lock_ctrl_if.sv
// Keypad/admin panel bundle: user and admin entries in, lock status out.
interface password_lock_ctrl_if;
    import password_pkg::*;

    logic              identity;
    logic              edit_switch;
    logic              confirm;
    logic [PSWD_W-1:0] entered_pswd;
    logic [PSWD_W-1:0] new_pswd;
    logic [PSWD_W-1:0] stored_pswd;
    logic [2:0]        state_code;
    logic [1:0]        time_of_error;
    logic              unlock;
    logic              alarm;
    logic              editing;
    logic              clr_entry;

    // Panel side: drives the entries, observes the lock.
    modport master (
        output identity, edit_switch, confirm, entered_pswd, new_pswd,
        input  stored_pswd, state_code, time_of_error, unlock, alarm,
               editing, clr_entry
    );

    // Lock controller side.
    modport slave (
        input  identity, edit_switch, confirm, entered_pswd, new_pswd,
        output stored_pswd, state_code, time_of_error, unlock, alarm,
               editing, clr_entry
    );

endinterface

// File: rtl/hold_timer.sv
// Unlock hold counter: counts 0..CYCLES-1 while enabled, restarts on load.
module hold_timer #(
    parameter int unsigned CYCLES = 150_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done_o = (cnt_q == LAST);

    // Next count: load restarts at zero, counting stops at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && !done_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/password_lock_ctrl.sv
// Password door lock controller: user entry/check, timed unlock,
// lockout after repeated failures, and admin password editing.
module password_lock_ctrl
    import password_pkg::*;
#(
    parameter logic [PSWD_W-1:0] DEFAULT_PSWD = DEFAULT_PSWD_INIT,
    parameter int unsigned       OPEN_CYCLES  = 150_000_000
) (
    input logic                 clk,
    input logic                 rst,
    password_lock_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [PSWD_W-1:0] stored_q, stored_d;
    logic [1:0]        err_q, err_d;
    logic              unlock_q, unlock_d;
    logic              alarm_q, alarm_d;
    logic              editing_q, editing_d;
    logic              clr_q, clr_d;

    logic              confirm_q;
    logic              armed_q;
    logic              cedge_q;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_done;

    // Failure counter increment that sticks at its maximum.
    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == MAX_ERRORS) ? MAX_ERRORS : 2'(v + 2'd1);
    endfunction

    // Confirm rising-edge detector; armed_q suppresses a button already
    // held down when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            confirm_q <= 1'b0;
            armed_q   <= 1'b0;
            cedge_q   <= 1'b0;
        end else begin
            confirm_q <= bus.confirm;
            armed_q   <= 1'b1;
            cedge_q   <= armed_q & bus.confirm & ~confirm_q;
        end
    end

    hold_timer #(
        .CYCLES (OPEN_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .count_i (tmr_en),
        .done_o  (tmr_done)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        stored_d = stored_q;
        err_d    = err_q;
        clr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.identity && bus.edit_switch) begin
                    state_d = ST_EDIT;
                end else if (bus.identity && cedge_q) begin
                    state_d = ST_ENTRY;
                    clr_d   = 1'b1;
                end
            end
            ST_ENTRY: begin
                // Leaving the user seat takes priority over a pending press.
                if (!bus.identity) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (cedge_q) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bus.entered_pswd == stored_q) begin
                    state_d = ST_OPEN;
                    err_d   = 2'd0;
                end else begin
                    err_d = sat_inc(err_q);
                    if (err_d == MAX_ERRORS) begin
                        state_d = ST_ALARM;
                    end else begin
                        state_d = ST_ENTRY;
                        clr_d   = 1'b1;
                    end
                end
            end
            ST_OPEN: begin
                if (tmr_done || cedge_q) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end
            end
            ST_ALARM: begin
                // Only an administrator press clears the lockout.
                if (!bus.identity && cedge_q) begin
                    state_d = ST_IDLE;
                    err_d   = 2'd0;
                end
            end
            ST_EDIT: begin
                if (!bus.edit_switch || bus.identity) begin
                    state_d = ST_IDLE;
                end else if (cedge_q && bcd_valid(bus.new_pswd)) begin
                    stored_d = bus.new_pswd;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unlock_d  = (state_d == ST_OPEN);
        alarm_d   = (state_d == ST_ALARM);
        editing_d = (state_d == ST_EDIT);
        tmr_load  = (state_d == ST_OPEN) && (state_q != ST_OPEN);
        tmr_en    = (state_q == ST_OPEN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stored_q  <= DEFAULT_PSWD;
            err_q     <= 2'd0;
            unlock_q  <= 1'b0;
            alarm_q   <= 1'b0;
            editing_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stored_q  <= stored_d;
            err_q     <= err_d;
            unlock_q  <= unlock_d;
            alarm_q   <= alarm_d;
            editing_q <= editing_d;
            clr_q     <= clr_d;
        end
    end

    assign bus.stored_pswd   = stored_q;
    assign bus.state_code    = state_q;
    assign bus.time_of_error = err_q;
    assign bus.unlock        = unlock_q;
    assign bus.alarm         = alarm_q;
    assign bus.editing       = editing_q;
    assign bus.clr_entry     = clr_q;

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Directed bench for password_lock_ctrl with a short unlock hold.
module tb_password_lock_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    password_lock_ctrl_if bus ();

    password_lock_ctrl #(
        .DEFAULT_PSWD (16'h1234),
        .OPEN_CYCLES  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One button press; the detected edge acts on the following clock.
    task automatic press();
        bus.confirm = 1'b1;
        step(1);
        bus.confirm = 1'b0;
    endtask

    task automatic attempt(input logic [15:0] p);
        bus.entered_pswd = p;
        press();
        step(2);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},  32'(bus.state_code),    32'd0);
        chk({tag, "_stored"}, 32'(bus.stored_pswd),   32'h1234);
        chk({tag, "_err"},    32'(bus.time_of_error), 32'd0);
        chk({tag, "_unlock"}, 32'(bus.unlock),        32'd0);
        chk({tag, "_alarm"},  32'(bus.alarm),         32'd0);
        chk({tag, "_edit"},   32'(bus.editing),       32'd0);
        chk({tag, "_clr"},    32'(bus.clr_entry),     32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.identity     = 1'b1;
        bus.edit_switch  = 1'b0;
        bus.confirm      = 1'b1;
        bus.entered_pswd = 16'h0000;
        bus.new_pswd     = 16'h0000;
        step(2);
        chk_reset("rst0");

        // Confirm held through reset release must not start an entry.
        rst = 1'b0;
        step(3);
        chk("held_confirm_state", 32'(bus.state_code), 32'd0);
        bus.confirm = 1'b0;
        step(1);

        // Correct password, unlock latency and hold length.
        press();
        step(1);
        chk("entry_state", 32'(bus.state_code), 32'd1);
        chk("entry_clr",   32'(bus.clr_entry),  32'd1);
        step(1);
        chk("entry_clr_pulse", 32'(bus.clr_entry), 32'd0);
        bus.entered_pswd = 16'h1234;
        press();
        chk("lat_unlock0", 32'(bus.unlock), 32'd0);
        step(1);
        chk("check_state", 32'(bus.state_code), 32'd2);
        chk("lat_unlock1", 32'(bus.unlock), 32'd0);
        step(1);
        chk("open_state",  32'(bus.state_code), 32'd3);
        chk("open_unlock", 32'(bus.unlock),     32'd1);
        step(7);
        chk("hold_last_unlock", 32'(bus.unlock), 32'd1);
        step(1);
        chk("hold_end_state",  32'(bus.state_code),    32'd0);
        chk("hold_end_unlock", 32'(bus.unlock),        32'd0);
        chk("hold_end_clr",    32'(bus.clr_entry),     32'd1);
        chk("hold_end_err",    32'(bus.time_of_error), 32'd0);

        // Three failures lead to lockout.
        press();
        step(1);
        attempt(16'h1111);
        chk("fail1_err",   32'(bus.time_of_error), 32'd1);
        chk("fail1_state", 32'(bus.state_code),    32'd1);
        chk("fail1_clr",   32'(bus.clr_entry),     32'd1);
        attempt(16'h1111);
        chk("fail2_err", 32'(bus.time_of_error), 32'd2);
        attempt(16'h1111);
        chk("fail3_err",   32'(bus.time_of_error), 32'd3);
        chk("fail3_alarm", 32'(bus.alarm),         32'd1);
        chk("fail3_state", 32'(bus.state_code),    32'd4);
        press();
        step(2);
        chk("alarm_user_state", 32'(bus.state_code),    32'd4);
        chk("alarm_user_err",   32'(bus.time_of_error), 32'd3);
        chk("alarm_user_alarm", 32'(bus.alarm),         32'd1);
        bus.identity = 1'b0;
        press();
        step(1);
        chk("admin_clear_state", 32'(bus.state_code),    32'd0);
        chk("admin_clear_alarm", 32'(bus.alarm),         32'd0);
        chk("admin_clear_err",   32'(bus.time_of_error), 32'd0);

        // Admin stores a new password.
        bus.edit_switch = 1'b1;
        step(1);
        chk("edit_state", 32'(bus.state_code), 32'd5);
        chk("edit_flag",  32'(bus.editing),    32'd1);
        bus.new_pswd = 16'h5678;
        press();
        step(1);
        bus.edit_switch = 1'b0;
        bus.identity    = 1'b1;
        chk("save_stored", 32'(bus.stored_pswd), 32'h5678);
        chk("save_state",  32'(bus.state_code),  32'd0);
        chk("save_edit",   32'(bus.editing),     32'd0);
        press();
        step(1);
        attempt(16'h5678);
        chk("new_pw_unlock", 32'(bus.unlock), 32'd1);
        press();
        step(1);
        chk("early_exit_state",  32'(bus.state_code), 32'd0);
        chk("early_exit_unlock", 32'(bus.unlock),     32'd0);
        chk("early_exit_clr",    32'(bus.clr_entry),  32'd1);
        press();
        step(1);
        attempt(16'h1234);
        chk("old_pw_state",  32'(bus.state_code),    32'd1);
        chk("old_pw_err",    32'(bus.time_of_error), 32'd1);
        chk("old_pw_unlock", 32'(bus.unlock),        32'd0);

        // Leaving entry as admin keeps the error count.
        bus.identity = 1'b0;
        step(1);
        chk("leave_state", 32'(bus.state_code),    32'd0);
        chk("leave_clr",   32'(bus.clr_entry),     32'd1);
        chk("leave_err",   32'(bus.time_of_error), 32'd1);

        // Invalid BCD is rejected; abort beats a simultaneous press.
        bus.edit_switch = 1'b1;
        step(1);
        bus.new_pswd = 16'h12A4;
        press();
        step(1);
        chk("bad_bcd_state",  32'(bus.state_code),  32'd5);
        chk("bad_bcd_stored", 32'(bus.stored_pswd), 32'h5678);
        bus.new_pswd = 16'h9999;
        bus.confirm  = 1'b1;
        step(1);
        bus.confirm     = 1'b0;
        bus.edit_switch = 1'b0;
        step(1);
        chk("abort_state",  32'(bus.state_code),  32'd0);
        chk("abort_stored", 32'(bus.stored_pswd), 32'h5678);
        chk("abort_edit",   32'(bus.editing),     32'd0);

        // Reset while open.
        bus.identity = 1'b1;
        press();
        step(1);
        attempt(16'h5678);
        chk("pre_rst_open", 32'(bus.unlock), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset("rst_open");
        step(1);
        rst = 1'b0;
        step(1);

        // Reset while in lockout.
        press();
        step(1);
        attempt(16'h1111);
        attempt(16'h1111);
        attempt(16'h1111);
        chk("pre_rst_alarm", 32'(bus.alarm), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset("rst_alarm");
        step(1);
        rst = 1'b0;
        step(1);

        // A success clears accumulated failures.
        press();
        step(1);
        attempt(16'h1111);
        attempt(16'h1111);
        chk("two_fail_err", 32'(bus.time_of_error), 32'd2);
        attempt(16'h1234);
        chk("recover_unlock", 32'(bus.unlock),        32'd1);
        chk("recover_err",    32'(bus.time_of_error), 32'd0);
        press();
        step(1);
        press();
        step(1);
        attempt(16'h1111);
        chk("refail_err", 32'(bus.time_of_error), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
